// File: rtl/sseg_display_arbiter.sv
// -----------------------------------------------------------------------------
// sseg_display_arbiter
//
// Shares an 8-digit, active-low seven-segment display between two pattern
// sources. A refresh divider scans the digits continuously. The display is
// granted to one source at a time, and grants change only at frame (full scan)
// boundaries so the display never tears. A hold counter and a priority pointer
// keep the sharing round-robin fair when both sources request.
//
// Parameters:
//   REFRESH_DIV : clock cycles spent on each digit (>= 2)
//   HOLD_SCANS  : minimum frames a grant is held under contention (>= 1)
//
// Ports:
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset
//   req[1:0]   : per-source display request
//   frame0     : source 0 patterns, byte k drives digit k (active-low, bit 7 = dp)
//   frame1     : source 1 patterns, same layout
//   grant[1:0] : one-hot current owner, 00 = idle (this is the arbiter state)
//   an[7:0]    : active-low digit enables, registered
//   sseg[7:0]  : active-low segments, registered
//   frame_tick : one-cycle pulse in the last cycle of each frame
//
// Handshake: req is level-sensitive and sampled only in the frame_tick cycle;
// the grant decided there takes effect on the edge that ends that cycle.
// -----------------------------------------------------------------------------
module sseg_display_arbiter #(
  parameter int REFRESH_DIV = 100000,
  parameter int HOLD_SCANS  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [63:0] frame0,
  input  logic [63:0] frame1,
  output logic [1:0]  grant,
  output logic [7:0]  an,
  output logic [7:0]  sseg,
  output logic        frame_tick
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int HW = (HOLD_SCANS > 1) ? $clog2(HOLD_SCANS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_SCANS - 1);

  // State encoding equals the one-hot grant value, so grant is the state.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT0 = 2'b01,
    GRANT1 = 2'b10
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      idx;
  logic [HW-1:0]   hold;
  logic            pri;

  assign grant      = state;
  assign frame_tick = (cnt == CNT_LAST) && (idx == 3'd7);

  // Refresh divider and digit scan; runs regardless of grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= 3'd0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      idx <= idx + 3'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Arbiter. Decisions are made only in the frame_tick cycle. Any change of
  // owner (including to/from idle) restarts the hold count; every new grant
  // points the priority at the other source.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      hold  <= '0;
      pri   <= 1'b0;
    end else if (frame_tick) begin
      case (state)
        IDLE: begin
          if (req == 2'b01 || (req == 2'b11 && !pri)) begin
            state <= GRANT0;
            hold  <= '0;
            pri   <= 1'b1;
          end else if (req == 2'b10 || (req == 2'b11 && pri)) begin
            state <= GRANT1;
            hold  <= '0;
            pri   <= 1'b0;
          end
        end
        GRANT0: begin
          if (!req[0]) begin
            hold <= '0;
            if (req[1]) begin
              state <= GRANT1;
              pri   <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else if (req[1] && hold == HOLD_MAX) begin
            state <= GRANT1;
            hold  <= '0;
            pri   <= 1'b0;
          end else if (hold != HOLD_MAX) begin
            hold <= hold + HW'(1);
          end
        end
        GRANT1: begin
          if (!req[1]) begin
            hold <= '0;
            if (req[0]) begin
              state <= GRANT0;
              pri   <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else if (req[0] && hold == HOLD_MAX) begin
            state <= GRANT0;
            hold  <= '0;
            pri   <= 1'b1;
          end else if (hold != HOLD_MAX) begin
            hold <= hold + HW'(1);
          end
        end
        default: begin
          state <= IDLE;
          hold  <= '0;
        end
      endcase
    end
  end

  // Pin drivers, registered from the pre-edge digit index and owner.
  // The frame inputs are sampled live.
  always_ff @(posedge clk) begin
    if (rst) begin
      an   <= 8'hFF;
      sseg <= 8'hFF;
    end else begin
      case (state)
        GRANT0: begin
          an   <= ~(8'b1 << idx);
          sseg <= frame0[{idx, 3'b000} +: 8];
        end
        GRANT1: begin
          an   <= ~(8'b1 << idx);
          sseg <= frame1[{idx, 3'b000} +: 8];
        end
        default: begin
          an   <= 8'hFF;
          sseg <= 8'hFF;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sseg_display_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sseg_display_arbiter
//
// Bench for sseg_display_arbiter with REFRESH_DIV=4, HOLD_SCANS=2 (32-cycle
// frame). A reference model tracks time since reset in cycles, derives the
// digit and frame boundary arithmetically, and applies the arbitration rules
// in terms of "owner", "other source" and "frames held". Each cycle it pushes
// the expected {grant, an, sseg, frame_tick} into a queue; an independent
// monitor pops and compares against the DUT shortly after each rising edge.
// -----------------------------------------------------------------------------
module tb_sseg_display_arbiter;

  localparam int RD    = 4;
  localparam int HS    = 2;
  localparam int FRAME = 8 * RD;

  // clock / reset block
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = 2'b00;
  logic [63:0] frame0 = 64'h0;
  logic [63:0] frame1 = 64'h0;
  logic [1:0]  grant;
  logic [7:0]  an;
  logic [7:0]  sseg;
  logic        frame_tick;

  always #5 clk = ~clk;

  sseg_display_arbiter #(
    .REFRESH_DIV(RD),
    .HOLD_SCANS (HS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .frame0    (frame0),
    .frame1    (frame1),
    .grant     (grant),
    .an        (an),
    .sseg      (sseg),
    .frame_tick(frame_tick)
  );

  // scoreboard
  logic [18:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;

  // reference model state
  int          t_m    = 0;
  logic [1:0]  g_m    = 2'b00;
  int          hold_m = 0;
  int          pri_m  = 0;
  logic [7:0]  an_m   = 8'hFF;
  logic [7:0]  sseg_m = 8'hFF;

  task automatic arbitrate(input logic [1:0] r);
    int winner;
    int keep;
    int o;
    winner = -1;
    keep   = 0;
    if (g_m == 2'b00) begin
      if (r == 2'b11)  winner = pri_m;
      else if (r[0])   winner = 0;
      else if (r[1])   winner = 1;
      else             keep = 1;
    end else begin
      o = g_m[1] ? 1 : 0;
      if (!r[o]) begin
        winner = r[1-o] ? 1 - o : -1;
      end else if (r[1-o] && hold_m >= HS - 1) begin
        winner = 1 - o;
      end else begin
        keep   = 1;
        hold_m = (hold_m + 1 > HS - 1) ? HS - 1 : hold_m + 1;
      end
    end
    if (!keep) begin
      hold_m = 0;
      if (winner < 0) begin
        g_m = 2'b00;
      end else begin
        g_m   = (winner == 0) ? 2'b01 : 2'b10;
        pri_m = 1 - winner;
      end
    end
  endtask

  // reference model: one step per rising edge, from pre-edge inputs
  initial begin
    int          digit;
    logic [63:0] f;
    forever begin
      @(posedge clk);
      if (rst) begin
        t_m    = 0;
        g_m    = 2'b00;
        hold_m = 0;
        pri_m  = 0;
        an_m   = 8'hFF;
        sseg_m = 8'hFF;
      end else begin
        digit = (t_m / RD) % 8;
        if (g_m == 2'b00) begin
          an_m   = 8'hFF;
          sseg_m = 8'hFF;
        end else begin
          f      = g_m[0] ? frame0 : frame1;
          an_m   = ~(8'd1 << digit);
          sseg_m = 8'((f >> (8 * digit)) & 64'hFF);
        end
        if ((t_m % FRAME) == FRAME - 1) arbitrate(req);
        t_m++;
      end
      exp_q.push_back({g_m, an_m, sseg_m, ((t_m % FRAME) == FRAME - 1) ? 1'b1 : 1'b0});
    end
  end

  // monitor
  initial begin
    logic [18:0] e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL queue_underflow cycle=%0d got grant=%b an=%h sseg=%h tick=%b required an expected entry",
                 cyc, grant, an, sseg, frame_tick);
      end else begin
        e = exp_q.pop_front();
        if ({grant, an, sseg, frame_tick} !== e) begin
          n_fail++;
          $display("FAIL outputs cycle=%0d got grant=%b an=%h sseg=%h tick=%b required grant=%b an=%h sseg=%h tick=%b",
                   cyc, grant, an, sseg, frame_tick, e[18:17], e[16:9], e[8:1], e[0]);
        end
      end
    end
  end

  // driver tasks
  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    run(n);
    rst = 1'b0;
  endtask

  initial begin
    // 1: reset and scan
    req = 2'b00;
    run(5);
    rst = 1'b0;
    run(70);

    // 2: single requester with a known pattern
    frame0 = 64'h0011223344556677;
    frame1 = {$urandom, $urandom};
    do_reset(1);
    req = 2'b01;
    run(80);

    // 3: contention from idle
    do_reset(2);
    req = 2'b11;
    run(200);

    // 4: drop mid-frame while owned by source 0, to the other and to idle
    do_reset(1);
    req = 2'b01;
    run(42);
    req = 2'b10;
    run(60);
    do_reset(1);
    req = 2'b01;
    run(42);
    req = 2'b00;
    run(40);

    // 5: hold saturation then contention
    do_reset(1);
    req = 2'b01;
    run(5 * FRAME);
    req = 2'b11;
    run(100);

    // 6: reset in the middle of a GRANT1 frame, then contention
    do_reset(1);
    req = 2'b10;
    run(FRAME + 21);
    do_reset(1);
    req = 2'b11;
    run(100);

    // randomized phase
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 19) == 0) req = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) frame0 = {$urandom, $urandom};
      if ($urandom_range(0, 49) == 0) frame1 = {$urandom, $urandom};
      rst = ($urandom_range(0, 299) == 0);
    end
    rst = 1'b0;
    run(40);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain got %0d entries left required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
